// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity
// mode constants and the expected-parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PAR       = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    // Parity bit the transmitter should have sent for this payload.
    // Unused upper payload bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [7:0] word, input logic [1:0] mode);
        return (mode == PARITY_ODD) ? ~(^word) : (^word);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with first-word-fall-through head and a one-cycle
// drop indication when a push is refused because the buffer is full.
module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int LGFLEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd,
    output logic [WIDTH-1:0]  rd_data,
    output logic              empty_n,
    output logic [LGFLEN:0]   fill,
    output logic              drop
);

    localparam int DEPTH = 1 << LGFLEN;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [LGFLEN-1:0] wr_ptr_reg;
    logic [LGFLEN-1:0] rd_ptr_reg;
    logic [LGFLEN:0]   fill_reg;
    logic              full;
    logic              do_push;
    logic              do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push alongside a pop; a pop on empty never happens.
    assign full    = fill_reg[LGFLEN];
    assign empty_n = |fill_reg;
    assign do_pop  = rd & empty_n;
    assign do_push = wr & (~full | do_pop);
    assign drop    = wr & full & ~do_pop;
    assign fill    = fill_reg;
    assign rd_data = mem[rd_ptr_reg];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill_reg <= fill_reg + 1'b1;
                2'b01:   fill_reg <= fill_reg - 1'b1;
                default: fill_reg <= fill_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with optional parity, sticky error flags and a receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104,
    parameter int          DATA_BITS       = 8,
    parameter int          PARITY          = 0,
    parameter int          LGFLEN          = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_uart_rx,
    input  logic                 i_rd,
    input  logic                 i_clr_err,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_empty_n,
    output logic [LGFLEN:0]      o_fill,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overflow
);

    localparam logic [23:0] HALF_BAUD   = CLOCKS_PER_BAUD / 24'd2;
    localparam logic [23:0] FULL_RELOAD = CLOCKS_PER_BAUD - 24'd1;
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);
    localparam bit          HAS_PARITY  = (PARITY != 0);

    rx_state_t            state_reg;
    logic                 rx_meta_reg;
    logic                 rx_sync_reg;
    logic                 rx_prev_reg;
    logic [23:0]          baud_cnt_reg;
    logic [2:0]           bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 bad_reg;
    logic                 push_reg;
    logic                 frame_err_reg;
    logic                 parity_err_reg;
    logic                 overflow_reg;
    logic                 baud_tick;
    logic                 fifo_drop;
    logic [7:0]           par_word;

    assign baud_tick = (baud_cnt_reg == 24'd0);

    // Zero-extend the payload so the shared parity helper sees a full byte.
    always_comb begin
        par_word                  = '0;
        par_word[DATA_BITS-1:0]   = shift_reg;
    end

    // Two-flop synchroniser plus one delayed copy for start-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= i_uart_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // Receive FSM: bit timing, payload assembly, error flags and push pulse.
    // Flag sets are written after the clear so a set wins a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            baud_cnt_reg   <= 24'd0;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= '0;
            bad_reg        <= 1'b0;
            push_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            push_reg <= 1'b0;
            if (i_clr_err) begin
                frame_err_reg  <= 1'b0;
                parity_err_reg <= 1'b0;
            end
            if (state_reg != ST_IDLE && state_reg != ST_WAIT_IDLE) begin
                baud_cnt_reg <= baud_tick ? FULL_RELOAD : baud_cnt_reg - 24'd1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (rx_prev_reg && !rx_sync_reg) begin
                        state_reg    <= ST_START;
                        baud_cnt_reg <= HALF_BAUD;
                        bad_reg      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        if (rx_sync_reg) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg   <= ST_DATA;
                            bit_cnt_reg <= 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        shift_reg   <= {rx_sync_reg, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg <= HAS_PARITY ? ST_PAR : ST_STOP;
                        end
                    end
                end
                ST_PAR: begin
                    if (baud_tick) begin
                        if (rx_sync_reg != parity_bit(par_word, 2'(PARITY))) begin
                            parity_err_reg <= 1'b1;
                            bad_reg        <= 1'b1;
                        end
                        state_reg <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (!rx_sync_reg) begin
                            frame_err_reg <= 1'b1;
                            bad_reg       <= 1'b1;
                            state_reg     <= ST_WAIT_IDLE;
                        end else begin
                            push_reg  <= ~bad_reg;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_sync_reg) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Sticky overflow flag fed by the FIFO's refused-push indication.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_reg <= 1'b0;
        end else begin
            if (i_clr_err) overflow_reg <= 1'b0;
            if (fifo_drop) overflow_reg <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH  (DATA_BITS),
        .LGFLEN (LGFLEN)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr      (push_reg),
        .wr_data (shift_reg),
        .rd      (i_rd),
        .rd_data (o_data),
        .empty_n (o_empty_n),
        .fill    (o_fill),
        .drop    (fifo_drop)
    );

    assign o_frame_err  = frame_err_reg;
    assign o_parity_err = parity_err_reg;
    assign o_overflow   = overflow_reg;

endmodule
